// File: rtl/axil_resp_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder.
package axil_resp_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;

   localparam int unsigned REG_W = 32;

   // Byte address to 32-bit word index; the two byte-offset bits are dropped.
   function automatic int unsigned word_idx(input logic [31:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding buffer. Accepts a new entry on the same edge
// it is popped, so a full buffer still sustains one transfer per cycle.
module axil_hold_reg #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             full_o,
   output logic [Width-1:0] data_o,
   input  logic             pop_i
);

   logic             full_q, full_d;
   logic [Width-1:0] data_q, data_d;
   logic             push;

   assign in_ready_o = !full_q || pop_i;
   assign push       = in_valid_i && in_ready_o;
   assign full_o     = full_q;
   assign data_o     = data_q;

   // Next state: a push wins over a pop landing on the same edge.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (push) begin
         full_d = 1'b1;
         data_d = in_data_i;
      end else if (pop_i) begin
         full_d = 1'b0;
      end
   end

   // Holding register with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit control registers as a flat vector.
// AW and W are captured independently in one-entry holds and committed together.
// Optional build macro AXIL_RESP_SLVERR_EN: out-of-range word indices answer SLVERR,
// writes to them are dropped and reads return zero; otherwise indices wrap.
module axil_reg_responder
   import axil_resp_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned NUM_REGS           = 4
) (
   input  logic                             S_AXI_ACLK,
   input  logic                             S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
   input  logic [2:0]                       S_AXI_AWPROT,
   input  logic                             S_AXI_AWVALID,
   output logic                             S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
   input  logic                             S_AXI_WVALID,
   output logic                             S_AXI_WREADY,
   output logic [1:0]                       S_AXI_BRESP,
   output logic                             S_AXI_BVALID,
   input  logic                             S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
   input  logic [2:0]                       S_AXI_ARPROT,
   input  logic                             S_AXI_ARVALID,
   output logic                             S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
   output logic [1:0]                       S_AXI_RRESP,
   output logic                             S_AXI_RVALID,
   input  logic                             S_AXI_RREADY,
   output logic [NUM_REGS*REG_W-1:0]        reg_q,
   output logic [NUM_REGS-1:0]              reg_wr_pulse
);

   localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned WHoldW = StrbW + C_S_AXI_DATA_WIDTH;
   localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [REG_W-1:0]              regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]           pulse_q;
   logic                          bvalid_q, rvalid_q;
   axi_resp_t                     bresp_q, rresp_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

   logic                          aw_full, w_full, commit, ar_hs;
   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [WHoldW-1:0]             w_hold;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
   logic [StrbW-1:0]              w_strb;

   int unsigned                   wr_word, rd_word;
   logic [IdxW-1:0]               wr_slot, rd_slot;
   logic                          wr_hit, rd_hit;
   axi_resp_t                     wr_resp, rd_resp;

   logic                          unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // A pending unaccepted B response blocks the next commit.
   assign commit = aw_full && w_full && (!bvalid_q || S_AXI_BREADY);
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_data = w_hold[C_S_AXI_DATA_WIDTH-1:0];
   assign w_strb = w_hold[WHoldW-1:C_S_AXI_DATA_WIDTH];

   axil_hold_reg #(
      .Width (C_S_AXI_ADDR_WIDTH)
   ) u_aw_hold (
      .clk_i      (S_AXI_ACLK),
      .rst_i      (S_AXI_ARESET),
      .in_valid_i (S_AXI_AWVALID),
      .in_ready_o (S_AXI_AWREADY),
      .in_data_i  (S_AXI_AWADDR),
      .full_o     (aw_full),
      .data_o     (aw_addr),
      .pop_i      (commit)
   );

   axil_hold_reg #(
      .Width (WHoldW)
   ) u_w_hold (
      .clk_i      (S_AXI_ACLK),
      .rst_i      (S_AXI_ARESET),
      .in_valid_i (S_AXI_WVALID),
      .in_ready_o (S_AXI_WREADY),
      .in_data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
      .full_o     (w_full),
      .data_o     (w_hold),
      .pop_i      (commit)
   );

   // Address decode for both channels: register slot, hit flag and response code.
   always_comb begin
      wr_word = word_idx(32'(aw_addr));
      rd_word = word_idx(32'(S_AXI_ARADDR));
      wr_slot = IdxW'(wr_word % NUM_REGS);
      rd_slot = IdxW'(rd_word % NUM_REGS);
`ifdef AXIL_RESP_SLVERR_EN
      wr_hit  = wr_word < NUM_REGS;
      rd_hit  = rd_word < NUM_REGS;
      wr_resp = wr_hit ? RESP_OKAY : RESP_SLVERR;
      rd_resp = rd_hit ? RESP_OKAY : RESP_SLVERR;
`else
      wr_hit  = 1'b1;
      rd_hit  = 1'b1;
      wr_resp = RESP_OKAY;
      rd_resp = RESP_OKAY;
`endif
   end

   // Write commit: byte-lane update, B response and one-cycle write strobe.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pulse_q  <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         pulse_q <= '0;
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
            if (wr_hit) begin
               for (int b = 0; b < StrbW; b++) begin
                  if (w_strb[b]) regs_q[wr_slot][8*b +: 8] <= w_data[8*b +: 8];
               end
               pulse_q[wr_slot] <= 1'b1;
            end
         end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // Read channel: capture on AR handshake; sees the pre-commit register value.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_hit ? regs_q[rd_slot] : '0;
         rresp_q  <= rd_resp;
      end else if (S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   // Flatten the register bank and drive the handshake outputs.
   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i*REG_W +: REG_W] = regs_q[i];
      reg_wr_pulse  = pulse_q;
      S_AXI_BVALID  = bvalid_q;
      S_AXI_BRESP   = bresp_q;
      S_AXI_RVALID  = rvalid_q;
      S_AXI_RDATA   = rdata_q;
      S_AXI_RRESP   = rresp_q;
      S_AXI_ARREADY = !rvalid_q || S_AXI_RREADY;
   end

endmodule
